rtn_addr_stack: RTL

Hardware return-address stack that supplies `Return_Addr` to the program-counter block. Call instructions push the address that follows the current `PC`. Return instructions pop it. The block holds a circular LIFO of `DEPTH` entries and presents the top entry as a registered output. It sits beside the PC/decode logic in the instruction-fetch path and flags overflow and underflow as sticky errors.

---
 rtl/risc_pkg.sv | 16 +
 rtl/rtn_addr_stack.sv | 128 ++++++++++++
 2 files changed

// File: rtl/risc_pkg.sv
// Shared fetch-path definitions: PC width, default return-stack depth and the
// decode of the {Push, Pop} request pair.
package risc_pkg;

  localparam int ADDR_W    = 8;
  localparam int RAS_DEPTH = 4;

  // Values are chosen so that ras_op_e'({Push, Pop}) decodes directly.
  typedef enum logic [1:0] {
    RAS_NOP  = 2'b00,
    RAS_POP  = 2'b01,
    RAS_PUSH = 2'b10,
    RAS_REPL = 2'b11
  } ras_op_e;

endpackage

// File: rtl/rtn_addr_stack.sv
// Return-address stack: circular LIFO of call return addresses with registered
// top-of-stack, empty/full status and sticky overflow/underflow flags.
module rtn_addr_stack #(
  parameter int DEPTH  = risc_pkg::RAS_DEPTH,
  parameter int ADDR_W = risc_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Push,
  input  logic              Pop,
  input  logic              Err_Clr,
  output logic [ADDR_W-1:0] Return_Addr,
  output logic              Stack_Empty,
  output logic              Stack_Full,
  output logic              Stack_Ovfl,
  output logic              Stack_Undfl
);
  import risc_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovfl_q, ovfl_d;
  logic              undfl_q, undfl_d;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] push_val;
  logic              is_empty, is_full;
  logic              ovfl_ev, undfl_ev;
  ras_op_e           op;

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    op       = ras_op_e'({Push, Pop});
    push_val = PC + ADDR_W'(1);
    is_empty = (cnt_q == '0);
    is_full  = (cnt_q == CNT_W'(DEPTH));
    tp_d     = tp_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_ptr   = tp_q;
    ovfl_ev  = 1'b0;
    undfl_ev = 1'b0;

    unique case (op)
      RAS_PUSH: begin
        // On a full stack tp+1 is the oldest slot, so the push overwrites it.
        tp_d   = tp_q + PTR_W'(1);
        wr_en  = 1'b1;
        wr_ptr = tp_q + PTR_W'(1);
        if (is_full) ovfl_ev = 1'b1;
        else         cnt_d   = cnt_q + CNT_W'(1);
      end
      RAS_POP: begin
        if (is_empty) begin
          undfl_ev = 1'b1;
        end else begin
          tp_d  = tp_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RAS_REPL: begin
        // Tail call replaces the top; with nothing to replace it is a push.
        wr_en = 1'b1;
        if (is_empty) begin
          tp_d   = tp_q + PTR_W'(1);
          wr_ptr = tp_q + PTR_W'(1);
          cnt_d  = CNT_W'(1);
        end
      end
      default: ;
    endcase

    // Any write this cycle lands at the new top, so forward it to the output.
    if (cnt_d == '0) ra_d = '0;
    else if (wr_en)  ra_d = push_val;
    else             ra_d = mem_q[tp_d];

    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    ovfl_d  = (ovfl_q  & ~Err_Clr) | ovfl_ev;
    undfl_d = (undfl_q & ~Err_Clr) | undfl_ev;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      tp_q    <= '0;
      cnt_q   <= '0;
      ra_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      undfl_q <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovfl_q  <= ovfl_d;
      undfl_q <= undfl_d;
    end
  end

  // NOTE: the entry array has no reset; cnt gates every read, so stale
  // contents are never observed and the flops stay plain enables.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= push_val;
  end

  assign Return_Addr = ra_q;
  assign Stack_Empty = empty_q;
  assign Stack_Full  = full_q;
  assign Stack_Ovfl  = ovfl_q;
  assign Stack_Undfl = undfl_q;

endmodule
